// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - EX-stage to multiply/divide unit request and result bundle
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, cancel_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, cancel_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative radix-2 mult/div unit owning HI/LO; MDU_FAST_MUL_EN selects single-cycle multiply
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic   clk,
    input  logic   reset,
    mdu_if.slave   bus
);
    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      acc_q, acc_d;     // product, or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   araw_q, araw_d;   // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;     // product / quotient negative
    logic               rneg_q, rneg_d;   // remainder negative (dividend sign)
    logic               div0_q, div0_d;
    logic               done_q, done_d;

    // Operand magnitudes: signed ops strip the sign here and restore it in FIX
    logic               op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    assign op_signed = ~bus.op_i[0];
    assign a_neg     = op_signed & bus.a_i[WIDTH-1];
    assign b_neg     = op_signed & bus.b_i[WIDTH-1];
    assign a_abs     = a_neg ? -bus.a_i : bus.a_i;
    assign b_abs     = b_neg ? -bus.b_i : bus.b_i;

    // One shift-add multiply step: add multiplicand on LSB, then shift right
    logic [WIDTH:0]     mul_sum;
    assign mul_sum = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // One restoring divide step: shift next dividend bit into remainder, trial subtract
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    assign div_rem_sh = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge     = div_rem_sh >= {1'b0, opnd_q};
    assign div_diff   = div_rem_sh[WIDTH-1:0] - opnd_q;

    // Sign-corrected results written in FIX
    logic [DW-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
    logic [DW-1:0]      fast_prod;
    assign fast_prod = op_signed
        ? {{WIDTH{bus.a_i[WIDTH-1]}}, bus.a_i} * {{WIDTH{bus.b_i[WIDTH-1]}}, bus.b_i}
        : {{WIDTH{1'b0}}, bus.a_i} * {{WIDTH{1'b0}}, bus.b_i};
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            araw_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            araw_q   <= araw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
        end
    end

    // Next-state, iteration and HI/LO write logic; cancel beats start and completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        araw_d   = araw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.cancel_i) begin
                    case (bus.op_i)
                        3'b100: hi_d = bus.a_i;
                        3'b101: lo_d = bus.a_i;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = bus.op_i[1];
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            div0_d   = bus.op_i[1] && (bus.b_i == '0);
                            araw_d   = bus.a_i;
                            opnd_d   = bus.op_i[1] ? b_abs : a_abs;
                            acc_d    = bus.op_i[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                            cnt_d    = '0;
                            state_d  = RUN;
`ifdef MDU_FAST_MUL_EN
                            if (!bus.op_i[1]) begin
                                acc_d   = fast_prod;
                                neg_d   = 1'b0;
                                state_d = FIX;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (bus.cancel_i) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q)
                        acc_d = {div_ge ? div_diff : div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
                    else
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == {CNT_W{1'b1}})
                        state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.cancel_i) begin
                    done_d = 1'b1;
                    if (div0_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - scoreboard bench for mdu_iterative
module tb_mdu_iterative;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) u_if ();

    mdu_iterative #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results as {HI, LO}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        case (op)
            3'b000: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'b001: r = {32'd0, a} * {32'd0, b};
            3'b010: begin
                if (b == 32'd0)                               r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                else r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int exp_busy(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
        if (!op[1]) return 1;
`endif
        return 33;
    endfunction

    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        u_if.start_i = 1'b1;
        u_if.op_i    = op;
        u_if.a_i     = a;
        u_if.b_i     = b;
        @(negedge clk);
        u_if.start_i = 1'b0;
    endtask

    // Issue an arithmetic op, wait for done, compare HI/LO and busy length
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_hilo);
        int busy_cnt;
        int cyc;
        logic [63:0] e;
        exp_q.push_back(exp_hilo);
        drive_start(op, a, b);
        busy_cnt = 0;
        cyc = 0;
        while (!u_if.done_o && cyc < 200) begin
            if (u_if.busy_o) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_seen"}, 64'(u_if.done_o), 64'd1);
        e = exp_q.pop_front();
        check({tag, " hilo"}, {u_if.hi_o, u_if.lo_o}, e);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy(op)));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(u_if.done_o), 64'd0);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        drive_start(op, a, 32'd0);
        check("move_busy", 64'(u_if.busy_o), 64'd0);
        check("move_done", 64'(u_if.done_o), 64'd0);
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        reset = 1'b1;
        u_if.start_i  = 1'b0;
        u_if.op_i     = 3'b000;
        u_if.a_i      = 32'd0;
        u_if.b_i      = 32'd0;
        u_if.cancel_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hilo", {u_if.hi_o, u_if.lo_o}, 64'd0);
        check("rst_busy", 64'(u_if.busy_o), 64'd0);
        check("rst_done", 64'(u_if.done_o), 64'd0);
        reset = 1'b0;

        do_op("mult_neg", 3'b000, 32'hFFFFFFFF, 32'h2, 64'hFFFFFFFF_FFFFFFFE);
        do_op("multu",    3'b001, 32'hFFFFFFFF, 32'h2, 64'h00000001_FFFFFFFE);
        do_op("div_neg",  3'b010, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD);
        do_op("divu",     3'b011, 32'd100, 32'd7, 64'h00000002_0000000E);
        do_op("divu_z",   3'b011, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF);
        do_op("div_z",    3'b010, 32'hFFFFFF00, 32'd0, 64'hFFFFFF00_FFFFFFFF);
        do_op("div_ovf",  3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        do_op("div_rs",   3'b010, 32'd7, 32'hFFFFFFFE, model(3'b010, 32'd7, 32'hFFFFFFFE));

        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 3));
            do_op("random", rop, ra, rb, model(rop, ra, rb));
        end

        move_to(3'b100, 32'h0000AAAA);
        check("mthi", 64'(u_if.hi_o), 64'h0000AAAA);
        move_to(3'b101, 32'h00005555);
        check("mtlo", 64'(u_if.lo_o), 64'h00005555);

        drive_start(3'b110, 32'h1111, 32'h2222);
        check("op110_busy", 64'(u_if.busy_o), 64'd0);
        check("op110_hilo", {u_if.hi_o, u_if.lo_o}, 64'h0000AAAA_00005555);

        u_if.cancel_i = 1'b1;
        drive_start(3'b100, 32'h777, 32'd0);
        u_if.cancel_i = 1'b0;
        check("start_cancel_drop", 64'(u_if.hi_o), 64'h0000AAAA);

        // Cancel at the 10th busy cycle of a multiply
        drive_start(3'b000, 32'h12345, 32'h6789);
        for (int k = 1; k < 10; k++) @(negedge clk);
        check("cancel_busy_before", 64'(u_if.busy_o), 64'd1);
        u_if.cancel_i = 1'b1;
        @(negedge clk);
        u_if.cancel_i = 1'b0;
        check("cancel_idle", 64'(u_if.busy_o), 64'd0);
        check("cancel_hilo", {u_if.hi_o, u_if.lo_o}, 64'h0000AAAA_00005555);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (u_if.done_o) done_seen++;
            @(negedge clk);
        end
        check("cancel_no_done", 64'(done_seen), 64'd0);

        // Asynchronous reset in the middle of a multiply
        drive_start(3'b000, 32'h12345, 32'h6789);
        for (int k = 1; k < 10; k++) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_hilo", {u_if.hi_o, u_if.lo_o}, 64'd0);
        check("midreset_busy", 64'(u_if.busy_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("after_reset", 3'b001, 32'd3, 32'd5, 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
